// File: rtl/load_align_unit.sv
// load_align_unit: in-order pipelined load unit between the MEM stage and an Avalon-MM read port.
// One word-aligned read per legal load; results are extended or LWL/LWR-merged at data return.
module load_align_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [5:0]              req_op,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [31:0]             req_merge,
  input  logic [TAG_WIDTH-1:0]    req_tag,
  output logic [ADDR_WIDTH-1:0]   avm_address,
  output logic                    avm_read,
  output logic [DATA_WIDTH/8-1:0] avm_byteenable,
  input  logic                    avm_waitrequest,
  input  logic [DATA_WIDTH-1:0]   avm_readdata,
  input  logic                    avm_readdatavalid,
  output logic                    resp_valid,
  output logic [31:0]             resp_data,
  output logic [TAG_WIDTH-1:0]    resp_tag,
  output logic                    resp_error,
  output logic                    busy
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int OB = $clog2(NB);
  localparam int PW = $clog2(DEPTH);

  localparam logic [PW-1:0] PONE  = PW'(1);
  localparam logic [PW:0]   CONE  = (PW+1)'(1);
  localparam logic [PW:0]   CFULL = (PW+1)'(DEPTH);

  localparam logic [2:0] K_LB  = 3'd0;
  localparam logic [2:0] K_LH  = 3'd1;
  localparam logic [2:0] K_LWL = 3'd2;
  localparam logic [2:0] K_LW  = 3'd3;
  localparam logic [2:0] K_LBU = 3'd4;
  localparam logic [2:0] K_LHU = 3'd5;
  localparam logic [2:0] K_LWR = 3'd6;

  function automatic logic [3:0] lane_mask(input logic [2:0] kind, input logic [1:0] k);
    logic [3:0] m;
    m = '0;
    case (kind)
      K_LB, K_LBU: m = 4'b0001 << k;
      K_LH, K_LHU: m = 4'b0011 << k;
      K_LW:        m = 4'b1111;
      K_LWL:       m = 4'b1111 >> (2'd3 - k);
      K_LWR:       m = 4'b1111 << k;
      default:     m = '0;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] fmt_word(input logic [2:0] kind, input logic [1:0] k,
                                           input logic [31:0] merge, input logic [31:0] d);
    logic [31:0] sh;
    logic [31:0] r;
    sh = d >> {k, 3'b000};
    r  = '0;
    case (kind)
      K_LB:  r = {{24{sh[7]}}, sh[7:0]};
      K_LBU: r = {24'd0, sh[7:0]};
      K_LH:  r = {{16{sh[15]}}, sh[15:0]};
      K_LHU: r = {16'd0, sh[15:0]};
      K_LW:  r = d;
      K_LWL: begin
        case (k)
          2'd0:    r = {d[7:0],  merge[23:0]};
          2'd1:    r = {d[15:0], merge[15:0]};
          2'd2:    r = {d[23:0], merge[7:0]};
          default: r = d;
        endcase
      end
      K_LWR: begin
        case (k)
          2'd0:    r = d;
          2'd1:    r = {merge[31:24], d[31:8]};
          2'd2:    r = {merge[31:16], d[31:16]};
          default: r = {merge[31:8],  d[31:24]};
        endcase
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Entry storage, indexed by allocation order
  logic [2:0]           e_kind  [DEPTH];
  logic [OB-1:0]        e_off   [DEPTH];
  logic [31:0]          e_merge [DEPTH];
  logic [TAG_WIDTH-1:0] e_tag   [DEPTH];
  logic                 e_err   [DEPTH];
  logic                 e_has   [DEPTH];
  logic [31:0]          e_data  [DEPTH];
  logic [PW-1:0]        pend_q  [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr, pend_wp, pend_rp, iss_idx;
  logic [PW:0]   used, pend_cnt;
  logic          live;

  logic [2:0]            req_kind;
  logic                  req_err;
  logic [OB-1:0]         req_wbase;
  logic [NB-1:0]         req_be;
  logic [ADDR_WIDTH-1:0] req_word;

  logic          accept, retire, iss_done, rdv_hit, head_hit;
  logic [PW-1:0] dst;
  logic [OB-1:0] dst_wbase;
  logic [31:0]   dst_word, dst_fmt;

  always_comb begin
    req_kind  = req_op[2:0];
    req_err   = 1'b0;
    if (req_op[5:3] != 3'b100 || req_op[2:0] == 3'b111)
      req_err = 1'b1;
    else if ((req_kind == K_LH || req_kind == K_LHU) && req_addr[0])
      req_err = 1'b1;
    else if (req_kind == K_LW && req_addr[1:0] != 2'b00)
      req_err = 1'b1;
    req_wbase = req_addr[OB-1:0] & ~OB'(3);
    req_be    = NB'(lane_mask(req_kind, req_addr[1:0])) << req_wbase;
    req_word  = {req_addr[ADDR_WIDTH-1:OB], {OB{1'b0}}};
  end

  // Returned data goes to the oldest read still awaiting data; error entries never enter pend_q
  always_comb begin
    dst       = pend_q[pend_rp];
    rdv_hit   = avm_readdatavalid && (pend_cnt != '0);
    dst_wbase = e_off[dst] & ~OB'(3);
    dst_word  = 32'(avm_readdata >> {dst_wbase, 3'b000});
    dst_fmt   = fmt_word(e_kind[dst], e_off[dst][1:0], e_merge[dst], dst_word);
    head_hit  = rdv_hit && (dst == rd_ptr);
    retire    = (used != '0) && (e_err[rd_ptr] || e_has[rd_ptr] || head_hit);
    iss_done  = avm_read && !avm_waitrequest;
    req_ready = live && ((used != CFULL) || retire) && (!avm_read || iss_done);
    accept    = req_valid && req_ready;
  end

  assign busy = (used != '0) || avm_read;

  // Allocation is written after the data return so a slot freed and reused in one cycle
  // starts clean.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        e_kind[i]  <= '0;
        e_off[i]   <= '0;
        e_merge[i] <= '0;
        e_tag[i]   <= '0;
        e_err[i]   <= 1'b0;
        e_has[i]   <= 1'b0;
        e_data[i]  <= '0;
        pend_q[i]  <= '0;
      end
    end else begin
      if (rdv_hit) begin
        e_has[dst]  <= 1'b1;
        e_data[dst] <= dst_fmt;
      end
      if (iss_done)
        pend_q[pend_wp] <= iss_idx;
      if (accept) begin
        e_kind[wr_ptr]  <= req_kind;
        e_off[wr_ptr]   <= req_addr[OB-1:0];
        e_merge[wr_ptr] <= req_merge;
        e_tag[wr_ptr]   <= req_tag;
        e_err[wr_ptr]   <= req_err;
        e_has[wr_ptr]   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      live           <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      pend_wp        <= '0;
      pend_rp        <= '0;
      used           <= '0;
      pend_cnt       <= '0;
      iss_idx        <= '0;
      avm_read       <= 1'b0;
      avm_address    <= '0;
      avm_byteenable <= '0;
      resp_valid     <= 1'b0;
      resp_data      <= '0;
      resp_tag       <= '0;
      resp_error     <= 1'b0;
    end else begin
      live <= 1'b1;
      if (accept)
        wr_ptr <= wr_ptr + PONE;
      if (retire)
        rd_ptr <= rd_ptr + PONE;
      if (iss_done)
        pend_wp <= pend_wp + PONE;
      if (rdv_hit)
        pend_rp <= pend_rp + PONE;

      unique case ({accept, retire})
        2'b10:   used <= used + CONE;
        2'b01:   used <= used - CONE;
        default: used <= used;
      endcase
      unique case ({iss_done, rdv_hit})
        2'b10:   pend_cnt <= pend_cnt + CONE;
        2'b01:   pend_cnt <= pend_cnt - CONE;
        default: pend_cnt <= pend_cnt;
      endcase

      if (accept && !req_err) begin
        avm_read       <= 1'b1;
        avm_address    <= req_word;
        avm_byteenable <= req_be;
        iss_idx        <= wr_ptr;
      end else if (iss_done) begin
        avm_read <= 1'b0;
      end

      resp_valid <= retire;
      if (retire) begin
        resp_tag   <= e_tag[rd_ptr];
        resp_error <= e_err[rd_ptr];
        if (e_err[rd_ptr])
          resp_data <= '0;
        else if (e_has[rd_ptr])
          resp_data <= e_data[rd_ptr];
        else
          resp_data <= dst_fmt;
      end
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
// tb_load_align_unit: random and directed loads against a behavioural load/bus reference model.
// A 32-bit instance carries most traffic; a 64-bit instance covers upper-word lane selection.
module tb_load_align_unit;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LWL = 6'b100010;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LWR = 6'b100110;

  typedef struct packed { logic [5:0] op; logic [31:0] addr; logic [31:0] merge; logic [4:0] tag; } req_t;
  typedef struct packed { logic err; logic [4:0] tag; logic [31:0] data; } rsp_t;
  typedef struct packed { logic [31:0] addr; logic [7:0] be; } bus_t;
  typedef struct packed { logic [63:0] data; int due; } rd_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic        req_valid, req_ready, avm_read, avm_waitrequest, avm_readdatavalid;
  logic        resp_valid, resp_error, busy;
  logic [5:0]  req_op;
  logic [31:0] req_addr, req_merge, avm_address, avm_readdata, resp_data;
  logic [4:0]  req_tag, resp_tag;
  logic [3:0]  avm_byteenable;

  logic        w_req_valid, w_req_ready, w_avm_read, w_avm_waitrequest, w_avm_readdatavalid;
  logic        w_resp_valid, w_resp_error, w_busy;
  logic [5:0]  w_req_op;
  logic [31:0] w_req_addr, w_req_merge, w_avm_address, w_resp_data;
  logic [63:0] w_avm_readdata;
  logic [4:0]  w_req_tag, w_resp_tag;
  logic [7:0]  w_avm_byteenable;

  load_align_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(4), .TAG_WIDTH(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .req_merge(req_merge), .req_tag(req_tag),
    .avm_address(avm_address), .avm_read(avm_read), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_tag(resp_tag),
    .resp_error(resp_error), .busy(busy)
  );

  load_align_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .DEPTH(4), .TAG_WIDTH(5)) dut64 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(w_req_valid), .req_ready(w_req_ready), .req_op(w_req_op), .req_addr(w_req_addr),
    .req_merge(w_req_merge), .req_tag(w_req_tag),
    .avm_address(w_avm_address), .avm_read(w_avm_read), .avm_byteenable(w_avm_byteenable),
    .avm_waitrequest(w_avm_waitrequest), .avm_readdata(w_avm_readdata),
    .avm_readdatavalid(w_avm_readdatavalid),
    .resp_valid(w_resp_valid), .resp_data(w_resp_data), .resp_tag(w_resp_tag),
    .resp_error(w_resp_error), .busy(w_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Sparse memory keyed by bus-aligned address; unknown words are filled randomly on first use
  logic [63:0] mem [int unsigned];

  function automatic logic [63:0] mem_at(input int unsigned a);
    if (!mem.exists(a)) mem[a] = {$urandom, $urandom};
    return mem[a];
  endfunction

  function automatic void model(input req_t r, input int dw, output rsp_t e, output bus_t b,
                                output bit iss);
    int unsigned a;
    int nb, o, k, w, first, last, v;
    bit bad;
    logic [31:0] d;
    logic [63:0] d64, m64;
    a = r.addr;
    nb = dw / 8;
    o = int'(a % nb);
    k = int'(a % 4);
    w = o / 4;
    first = 0; last = -1; bad = 0;
    e.tag = r.tag; e.err = 1'b0; e.data = '0;
    b.addr = a - o; b.be = '0; iss = 0;
    case (r.op)
      OP_LB, OP_LBU: begin first = o; last = o; end
      OP_LH, OP_LHU: begin first = o; last = o + 1; bad = (a % 2) != 0; end
      OP_LW:         begin first = o; last = o + 3; bad = k != 0; end
      OP_LWL:        begin first = 4 * w; last = 4 * w + k; end
      OP_LWR:        begin first = 4 * w + k; last = 4 * w + 3; end
      default:       bad = 1;
    endcase
    if (bad) begin
      e.err = 1'b1;
      return;
    end
    iss = 1;
    for (int i = first; i <= last; i++) b.be[i] = 1'b1;
    d64 = mem_at(b.addr) >> (32 * w);
    d   = d64[31:0];
    d64 = {32'd0, d};
    m64 = {32'd0, r.merge};
    case (r.op)
      OP_LB, OP_LBU: begin
        v = int'((d >> (8 * k)) & 32'hFF);
        if (r.op == OP_LB && v >= 128) v -= 256;
        e.data = 32'(v);
      end
      OP_LH, OP_LHU: begin
        v = int'((d >> (8 * k)) & 32'hFFFF);
        if (r.op == OP_LH && v >= 32768) v -= 65536;
        e.data = 32'(v);
      end
      OP_LW:  e.data = d;
      OP_LWL: e.data = 32'((d64 << (8 * (3 - k))) | (m64 & ((64'd1 << (8 * (3 - k))) - 1)));
      default: e.data = 32'((d64 >> (8 * k)) | (m64 & ~((64'd1 << (32 - 8 * k)) - 1)));
    endcase
  endfunction

  req_t stim_q[$];
  rsp_t exp_q[$];
  bus_t bus_q[$];
  rd_t  rd_q[$];
  req_t cur;
  int   cyc = 0, n_acc = 0, n_rd = 0;
  int   wait_pct = 0, lat_max = 0, gap_pct = 0, force_wait = 0;
  bit   hold_rdv = 0, acc_last = 0, stall_prev = 0;
  logic [35:0] stall_sig;

  function automatic req_t mk(input logic [5:0] op, input logic [31:0] addr,
                              input logic [31:0] merge, input logic [4:0] tag);
    req_t r;
    r.op = op; r.addr = addr; r.merge = merge; r.tag = tag;
    return r;
  endfunction

  task automatic step();
    rsp_t e;
    bus_t b;
    rd_t  rd;
    bit   iss;
    @(negedge clk);
    cyc++;
    if (resp_valid) begin
      if (exp_q.size() == 0) check("spurious_resp", 64'(resp_valid), 64'(0));
      else begin
        e = exp_q.pop_front();
        check("resp", 64'({resp_error, resp_tag, resp_data}), 64'({e.err, e.tag, e.data}));
      end
    end
    avm_readdatavalid = 1'b0;
    avm_readdata = $urandom;
    if (!hold_rdv && rd_q.size() > 0 && rd_q[0].due <= cyc) begin
      rd = rd_q.pop_front();
      avm_readdatavalid = 1'b1;
      avm_readdata = rd.data[31:0];
    end
    avm_waitrequest = int'($urandom_range(99)) < wait_pct;
    if (force_wait > 0 && avm_read) begin
      avm_waitrequest = 1'b1;
      force_wait--;
    end
    if (!req_valid || acc_last) begin
      req_valid = 1'b0;
      if (stim_q.size() > 0 && int'($urandom_range(99)) >= gap_pct) begin
        cur = stim_q.pop_front();
        req_valid = 1'b1;
        req_op = cur.op; req_addr = cur.addr; req_merge = cur.merge; req_tag = cur.tag;
      end
    end
    #1;
    acc_last = req_valid && req_ready;
    if (acc_last) begin
      model(cur, 32, e, b, iss);
      exp_q.push_back(e);
      if (iss) bus_q.push_back(b);
      n_acc++;
    end
    if (stall_prev)
      check("stall_hold", 64'({avm_read, avm_address, avm_byteenable}), 64'({1'b1, stall_sig}));
    if (avm_read && !avm_waitrequest) begin
      n_rd++;
      if (bus_q.size() == 0) check("spurious_read", 64'(avm_read), 64'(0));
      else begin
        b = bus_q.pop_front();
        check("bus_read", 64'({avm_address, avm_byteenable}), 64'({b.addr, b.be[3:0]}));
        rd.data = mem_at(b.addr);
        rd.due  = cyc + 1 + int'($urandom_range(lat_max));
        rd_q.push_back(rd);
      end
    end
    stall_prev = avm_read && avm_waitrequest;
    stall_sig  = {avm_address, avm_byteenable};
  endtask

  task automatic run_until_idle(input int max_cyc);
    int n;
    n = 0;
    while ((stim_q.size() != 0 || exp_q.size() != 0 || (req_valid && !acc_last)) && n < max_cyc) begin
      step();
      n++;
    end
    check("drain_pending", 64'(exp_q.size() + bus_q.size() + stim_q.size()), 64'(0));
    check("idle_busy", 64'(busy), 64'(0));
  endtask

  task automatic load64(input req_t r);
    rsp_t e;
    bus_t b;
    bit   iss, pulse, got;
    int   reads, t_rdv;
    model(r, 64, e, b, iss);
    @(negedge clk);
    w_req_valid = 1'b1;
    w_req_op = r.op; w_req_addr = r.addr; w_req_merge = r.merge; w_req_tag = r.tag;
    #1 check("w_ready", 64'(w_req_ready), 64'(1));
    pulse = 0; got = 0; reads = 0; t_rdv = -10;
    for (int n = 0; n < 12 && !got; n++) begin
      @(negedge clk);
      w_req_valid = 1'b0;
      w_avm_readdatavalid = pulse;
      w_avm_readdata = pulse ? mem_at(b.addr) : 64'd0;
      if (pulse) t_rdv = n;
      pulse = 0;
      if (w_resp_valid) begin
        check("w_resp", 64'({w_resp_error, w_resp_tag, w_resp_data}), 64'({e.err, e.tag, e.data}));
        if (iss) check("w_latency", 64'(n - t_rdv), 64'(1));
        got = 1;
      end
      if (w_avm_read) begin
        reads++;
        check("w_bus", 64'({w_avm_address, w_avm_byteenable}), 64'({b.addr, b.be}));
        pulse = 1;
      end
    end
    w_avm_readdatavalid = 1'b0;
    check("w_reads", 64'(reads), 64'(iss));
    check("w_got", 64'(got), 64'(1));
  endtask

  function automatic req_t rand_req();
    req_t r;
    logic [5:0] op;
    case ($urandom_range(8))
      0: op = OP_LB;  1: op = OP_LBU; 2: op = OP_LH;  3: op = OP_LHU;
      4: op = OP_LW;  5: op = OP_LWL; 6: op = OP_LWR; default: op = 6'($urandom);
    endcase
    r.op = op;
    r.addr = 32'h1000 + $urandom_range(63);
    if ($urandom_range(1) == 0) r.addr[1:0] = 2'b00;
    r.merge = $urandom;
    r.tag = 5'($urandom);
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0;
    reset_n = 1'b1;
    req_valid = 0; req_op = '0; req_addr = '0; req_merge = '0; req_tag = '0;
    avm_waitrequest = 0; avm_readdata = '0; avm_readdatavalid = 0;
    w_req_valid = 0; w_req_op = '0; w_req_addr = '0; w_req_merge = '0; w_req_tag = '0;
    w_avm_waitrequest = 0; w_avm_readdata = '0; w_avm_readdatavalid = 0;
    #2 reset_n = 1'b0;
    #1;
    check("reset_bus", 64'({req_ready, avm_read, avm_address, avm_byteenable, busy}), 64'(0));
    check("reset_resp", 64'({resp_valid, resp_data, resp_tag, resp_error}), 64'(0));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    mem[32'h1000] = 64'h0000_0000_80FF_FF00;
    stim_q.push_back(mk(OP_LB, 32'h1003, 32'h0, 5'd7));
    run_until_idle(50);

    mem[32'h1000] = 64'h0000_0000_AABB_CCDD;
    stim_q.push_back(mk(OP_LWL, 32'h1001, 32'h1122_3344, 5'd3));
    stim_q.push_back(mk(OP_LWR, 32'h1002, 32'h1122_3344, 5'd4));
    run_until_idle(50);

    rd0 = n_rd;
    stim_q.push_back(mk(OP_LW, 32'h1000, 32'h0, 5'd10));
    stim_q.push_back(mk(OP_LH, 32'h1001, 32'h0, 5'd11));
    stim_q.push_back(mk(OP_LW, 32'h1004, 32'h0, 5'd12));
    run_until_idle(50);
    check("err_no_read", 64'(n_rd - rd0), 64'(2));

    rd0 = n_rd;
    force_wait = 3;
    stim_q.push_back(mk(OP_LW, 32'h1008, 32'h0, 5'd13));
    run_until_idle(50);
    check("stall_one_read", 64'(n_rd - rd0), 64'(1));

    hold_rdv = 1;
    n_acc = 0;
    for (int i = 0; i < 6; i++) stim_q.push_back(mk(OP_LW, 32'h1010 + 4 * i, 32'h0, 5'(20 + i)));
    repeat (12) step();
    check("full_accepts", 64'(n_acc), 64'(4));
    check("full_ready", 64'(req_ready), 64'(0));
    check("full_busy", 64'(busy), 64'(1));
    hold_rdv = 0;
    run_until_idle(100);
    check("full_total", 64'(n_acc), 64'(6));

    wait_pct = 30; lat_max = 4; gap_pct = 20;
    for (int i = 0; i < 200; i++) stim_q.push_back(rand_req());
    run_until_idle(5000);
    wait_pct = 0; lat_max = 0; gap_pct = 0;

    mem[32'h2000] = 64'hA1B2_9CD4_E5F6_0718;
    load64(mk(OP_LBU, 32'h2005, 32'h0, 5'd5));
    load64(mk(OP_LW,  32'h2004, 32'h0, 5'd6));
    load64(mk(OP_LH,  32'h2002, 32'h0, 5'd7));
    load64(mk(OP_LWR, 32'h2007, 32'hDEAD_BEEF, 5'd8));
    load64(mk(OP_LWL, 32'h2006, 32'hCAFE_F00D, 5'd9));
    load64(mk(OP_LHU, 32'h2003, 32'h0, 5'd10));

    hold_rdv = 1;
    for (int i = 0; i < 3; i++) stim_q.push_back(mk(OP_LB, 32'h1020 + i, 32'h0, 5'(i)));
    repeat (8) step();
    check("pre_reset_accepts", 64'(exp_q.size()), 64'(3));
    #2 reset_n = 1'b0;
    #1;
    check("midreset_bus", 64'({req_ready, avm_read, avm_address, avm_byteenable, busy}), 64'(0));
    check("midreset_resp", 64'({resp_valid, resp_data, resp_tag, resp_error}), 64'(0));
    stim_q.delete(); exp_q.delete(); bus_q.delete(); rd_q.delete();
    req_valid = 1'b0; acc_last = 0; stall_prev = 0; hold_rdv = 0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("stray_no_resp", 64'(resp_valid), 64'(0));
      avm_readdatavalid = (i < 3);
      avm_readdata = $urandom;
    end
    avm_readdatavalid = 1'b0;
    check("stray_busy", 64'(busy), 64'(0));
    stim_q.push_back(mk(OP_LHU, 32'h1022, 32'h0, 5'd30));
    run_until_idle(50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
